// File: rtl/rpt_pkg.sv
// Shared state encoding and counter sizing for the RPT single-port RAM streamer.
package rpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } rpt_state_e;

  // Counters must be able to hold DEPTH itself, so a full 2**ADDR_W run needs an extra bit.
  function automatic int rpt_cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rpt_fifo2.sv
// Two-entry synchronous FIFO that soaks up the RAM's registered read under backpressure.
module rpt_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [1:0][DATA_W-1:0] mem;
  logic                   wp;
  logic                   rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rp];

endmodule

// File: rtl/rpt_spram_streamer.sv
// Fills DEPTH words of a single-port RAM from a stream, then drains them back out as a stream.
module rpt_spram_streamer
  import rpt_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 18,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_start,
  input  logic                     rd_start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic signed [DATA_W-1:0] ram_wdata,
  input  logic signed [DATA_W-1:0] ram_rdata
);

  localparam int            CW   = rpt_cnt_w(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEP  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  rpt_state_e    state, state_nx;
  logic [CW-1:0] wr_ptr, rd_ptr, out_cnt;
  logic          pending;
  logic          done_q;

  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic [2:0]        inflight;
  logic              fill_hs, pop, issue, fill_end, drain_end;

  rpt_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pending),
    .pop  (pop),
    .din  (ram_rdata),
    .head (head),
    .occ  (occ)
  );

  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    m_valid   = (occ != 2'd0);
    m_data    = head;
    m_last    = m_valid && (out_cnt == LAST);
    busy      = (state != ST_IDLE);
    done      = done_q;
    pop       = m_valid && m_ready;
    fill_hs   = (state == ST_FILL) && s_valid;
    // Words buffered or in flight after this edge; the 2-entry FIFO must never overflow.
    inflight  = {1'b0, occ} + {2'b0, pending} - {2'b0, pop};
    issue     = (state == ST_DRAIN) && (rd_ptr < DEP) && (inflight < 3'd2);
    fill_end  = fill_hs && (wr_ptr == LAST);
    drain_end = pop && (out_cnt == LAST);

    if (state == ST_FILL) s_ready = 1'b1;
    if (fill_hs) begin
      ram_we    = 1'b1;
      ram_addr  = ADDR_W'(wr_ptr);
      ram_wdata = s_data;
    end else if (issue) begin
      ram_addr  = ADDR_W'(rd_ptr);
    end

    case (state)
      ST_IDLE: begin
        if (wr_start)      state_nx = ST_FILL;
        else if (rd_start) state_nx = ST_DRAIN;
      end
      ST_FILL:  if (fill_end)  state_nx = ST_IDLE;
      ST_DRAIN: if (drain_end) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_cnt <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= fill_end || drain_end;
      pending <= issue;
      if (fill_hs) wr_ptr <= fill_end ? '0 : wr_ptr + ONE;
      if (issue)   rd_ptr <= rd_ptr + ONE;
      if (pop)     out_cnt <= out_cnt + ONE;
      if (drain_end) begin
        rd_ptr  <= '0;
        out_cnt <= '0;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rpt_spram_streamer.md
Name: rpt_spram_streamer

Overview:
- Initiator-side controller for the single-port feature/weight RAM (`rpt_spram`).
- Fill phase: accepts a valid/ready write stream and writes DEPTH words to addresses 0..DEPTH-1.
- Drain phase: reads the same DEPTH words back and emits them as a valid/ready stream with last-marker.
- Absorbs the RAM's 1-cycle registered read latency under downstream backpressure. Sits between the CNN datapath stream ports and each `rpt_spram` instance.

Parameters:
- ADDR_W, 5, RAM address width.
- DEPTH, 18, words per fill/drain; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- DATA_W, 8, signed data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_start  in  1  pulse in IDLE: begin fill.
- rd_start  in  1  pulse in IDLE: begin drain.
- s_valid  in  1  write-stream valid.
- s_ready  out  1  write-stream ready.
- s_data  in  DATA_W  write-stream data, signed.
- m_valid  out  1  read-stream valid.
- m_ready  in  1  read-stream ready.
- m_data  out  DATA_W  read-stream data, signed.
- m_last  out  1  high with word index DEPTH-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of fill or drain.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM registered read data, valid the cycle after its address was presented.

Behaviour:
- Reset (async assert, sync-release use):
  - state=IDLE; wr_ptr=rd_ptr=out_cnt=0; output buffer empty; pending=0.
  - Outputs: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - RAM contents untouched. Reset mid-fill or mid-drain aborts with no done pulse.
- States: IDLE, FILL, DRAIN.
- IDLE transitions:
  - wr_start -> FILL.
  - else rd_start -> DRAIN.
  - wr_start and rd_start in the same cycle: FILL wins and rd_start is dropped.
  - Starts while busy are ignored.
- FILL:
  - s_ready=1.
  - ram_we = s_valid&s_ready, combinational; ram_addr=wr_ptr; ram_wdata=s_data, same cycle.
  - wr_ptr increments per handshake.
  - On the handshake with wr_ptr==DEPTH-1: wr_ptr<=0, state<=IDLE, done=1 next cycle.
  - s_valid gaps stall without side effects.
- DRAIN, read issue:
  - A read is issued (ram_addr=rd_ptr, ram_we=0) when rd_ptr<DEPTH and (occ + pending - pop) < 2.
  - occ = buffer entries (0..2); pending = a read issued last cycle; pop = m_valid&m_ready this cycle.
  - pending<=issue.
- DRAIN, capture and output:
  - When pending=1, ram_rdata is pushed into the 2-entry FIFO at that edge.
  - m_valid=(occ>0); m_data=FIFO head.
  - m_last=(out_cnt==DEPTH-1)&m_valid.
  - Each pop increments out_cnt.
  - On the pop with out_cnt==DEPTH-1: clear pointers/counters, state<=IDLE, done=1 next cycle.
- Latency and throughput:
  - rd_start sampled at edge E0 -> addr 0 driven after E0 -> m_valid high after E2 (2 cycles).
  - Sustained 1 word/cycle with m_ready held high.
  - FIFO never overflows; never underflows.
  - m_data/m_last stable while m_valid&!m_ready.
- ram_addr is 0 whenever no access is issued. ram_we=0 outside FILL handshakes.
- done is a 1-cycle pulse only; busy=0 in the same cycle done=1.
- Address width: pointers ADDR_W bits; rd_ptr/out_cnt may need ADDR_W+1 bits when DEPTH==2**ADDR_W.
  - Rule: counters are clog2(DEPTH+1) wide.
  - ram_addr is the low ADDR_W bits of the pointer.

Decomposition:
- Shared package rpt_pkg: state encoding (ST_IDLE=2'd0, ST_FILL=2'd1, ST_DRAIN=2'd2), and a clog2-based counter-width constant function.
- One sub-module: rpt_fifo2.
  - 2-entry synchronous FIFO, DATA_W wide, with push/pop/occ/head.
  - Same clk/rst_n, async active-low reset.

Test Plan:
- Fill then drain with defaults (DEPTH=18), stream values -9..8 with s_valid constant:
  - 18 writes to addr 0..17; done 1 cycle after the 18th handshake.
  - rd_start -> m_data -9..8 in order, first m_valid 2 cycles after rd_start.
  - m_last only on value 8; 18 consecutive beats with m_ready=1.
- Backpressure: during drain, toggle m_ready 1,0,0,1 repeatedly:
  - No lost or duplicated words; m_data held while stalled.
  - ram_addr issue stops while FIFO+pending is full.
- Source gaps: s_valid pattern 1,0,1,1,0 during fill:
  - ram_we only on handshake cycles; addresses contiguous 0..17.
- Simultaneous and illegal starts:
  - wr_start&rd_start in IDLE -> FILL.
  - rd_start during FILL ignored; busy=1 throughout.
- Reset mid-drain after 5 beats: assert rst_n=0 asynchronously mid-cycle:
  - All outputs 0 immediately; no done pulse.
  - A new rd_start yields full 18 words from addr 0 with unchanged data.
- Boundary DEPTH=32, ADDR_W=5:
  - Address wraps never exceed 31; m_last on word 31.
  - Counters do not alias 32 to 0 before done.
